// File: rtl/channel_pkg.sv
// Shared types and helpers for the channel replay engine.
package channel_pkg;

  localparam int unsigned SMPL_W         = 8;
  localparam int unsigned PAIRS_PER_WORD = 4;
  localparam int unsigned PAIR_IDX_W     = 2;
  localparam int unsigned DEC_W          = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } replay_state_t;

  typedef struct packed {
    logic h;
    logic l;
  } ch_pair_t;

  // Pair idx of a packed sample word: odd bit -> CH_H, even bit -> CH_L.
  function automatic ch_pair_t pair_sel(input logic [SMPL_W-1:0] word,
                                        input logic [PAIR_IDX_W-1:0] idx);
    logic [1:0] bits;
    bits = word[{idx, 1'b0} +: 2];
    return ch_pair_t'(bits);
  endfunction

endpackage

// File: rtl/channel_replay_fifo.sv
// Small synchronous FIFO with show-ahead read data; full words refuse pushes.
module channel_replay_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/channel_replay.sv
// Replays buffered sample words onto CH_H/CH_L, one pair per 2^dec cycles.
// Define CHANNEL_REPLAY_HOLD_LAST_EN to hold the last pair instead of idle levels.
module channel_replay
  import channel_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DEC_MAX = 9,
  parameter logic        IDLE_H  = 1'b0,
  parameter logic        IDLE_L  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DEC_W-1:0]  decimator,
  input  logic [SMPL_W-1:0] smpl,
  input  logic              smpl_vld,
  output logic              smpl_rdy,
  output logic              CH_H,
  output logic              CH_L,
  output logic              busy,
  output logic              underrun
);

  localparam int unsigned HOLD_W = (DEC_MAX < 1) ? 1 : DEC_MAX;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  replay_state_t         state;
  replay_state_t         state_nxt;
  logic [DEC_W-1:0]      dec_q;
  logic [DEC_W-1:0]      dec_nxt;
  logic [DEC_W-1:0]      dec_sat;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [HOLD_W-1:0]     hold_nxt;
  logic [HOLD_W-1:0]     hold_max;
  logic [PAIR_IDX_W-1:0] pair_idx;
  logic [PAIR_IDX_W-1:0] idx_nxt;
  logic [SMPL_W-1:0]     word_q;
  logic [SMPL_W-1:0]     word_nxt;
  ch_pair_t              ch_nxt;
  ch_pair_t              idle_pair;
  logic                  underrun_nxt;

  logic [SMPL_W-1:0]     fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_push;
  logic                  has_word;
  logic                  hold_done;
  logic                  last_pair;
  logic                  word_end;
  logic                  load;

  assign smpl_rdy  = (fifo_count != CNT_W'(DEPTH));
  assign fifo_push = smpl_vld && !fifo_full;
  assign has_word  = !fifo_empty;
  assign busy      = (state == SHIFT);
  assign idle_pair = ch_pair_t'({IDLE_H, IDLE_L});

  assign dec_sat   = ({28'd0, decimator} > DEC_MAX) ? DEC_W'(DEC_MAX) : decimator;
  assign hold_max  = HOLD_W'((32'd1 << dec_q) - 32'd1);
  assign hold_done = (hold_cnt == hold_max);
  assign last_pair = (pair_idx == PAIR_IDX_W'(PAIRS_PER_WORD - 1));
  assign word_end  = (state == SHIFT) && hold_done && last_pair;
  assign load      = en && has_word && ((state == IDLE) || word_end);

  channel_replay_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SMPL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (smpl),
    .pop   (load),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (word_end && !load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the pair shifter and the registered outputs.
  always_comb begin
    ch_nxt       = ch_pair_t'({CH_H, CH_L});
    underrun_nxt = 1'b0;
    hold_nxt     = hold_cnt;
    idx_nxt      = pair_idx;
    dec_nxt      = dec_q;
    word_nxt     = word_q;
    if (load) begin
      word_nxt = fifo_dout;
      dec_nxt  = dec_sat;
      idx_nxt  = '0;
      hold_nxt = '0;
      ch_nxt   = pair_sel(fifo_dout, '0);
    end else if (state == SHIFT) begin
      if (hold_done) begin
        hold_nxt = '0;
        if (!last_pair) begin
          idx_nxt = pair_idx + PAIR_IDX_W'(1);
          ch_nxt  = pair_sel(word_q, pair_idx + PAIR_IDX_W'(1));
        end else begin
          idx_nxt      = '0;
          underrun_nxt = en;
`ifdef CHANNEL_REPLAY_HOLD_LAST_EN
          ch_nxt       = ch_pair_t'({CH_H, CH_L});
`else
          ch_nxt       = idle_pair;
`endif
        end
      end else begin
        hold_nxt = hold_cnt + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      CH_H     <= IDLE_H;
      CH_L     <= IDLE_L;
      underrun <= 1'b0;
      hold_cnt <= '0;
      pair_idx <= '0;
      dec_q    <= '0;
      word_q   <= '0;
    end else begin
      CH_H     <= ch_nxt.h;
      CH_L     <= ch_nxt.l;
      underrun <= underrun_nxt;
      hold_cnt <= hold_nxt;
      pair_idx <= idx_nxt;
      dec_q    <= dec_nxt;
      word_q   <= word_nxt;
    end
  end

endmodule

// File: tb/tb_channel_replay.sv
// Scoreboard bench for channel_replay: stimulus queues expected per-cycle output, a monitor compares.
module tb_channel_replay;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] decimator;
  logic [7:0] smpl;
  logic       smpl_vld;
  logic       smpl_rdy;
  logic       CH_H;
  logic       CH_L;
  logic       busy;
  logic       underrun;

  typedef struct packed {
    logic [1:0] ch;
    logic       bsy;
    logic       und;
  } obs_t;

  obs_t       exp_q[$];
  obs_t       e;
  obs_t       got;
  logic [1:0] last_ch = 2'b00;
  logic       mon_en  = 1'b0;
  logic       in_word = 1'b0;
  int         checks   = 0;
  int         failures = 0;

  channel_replay dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .decimator (decimator),
    .smpl      (smpl),
    .smpl_vld  (smpl_vld),
    .smpl_rdy  (smpl_rdy),
    .CH_H      (CH_H),
    .CH_L      (CH_L),
    .busy      (busy),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_idle(input logic [1:0] last);
`ifdef CHANNEL_REPLAY_HOLD_LAST_EN
    return last;
`else
    return 2'b00;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, req);
    end
  endtask

  // Queue one word's output trace: four pairs, each held 2^dec cycles.
  task automatic exp_word(input logic [7:0] w, input int dec);
    logic [1:0] pr;
    for (int p = 0; p < 4; p++) begin
      pr = {w[2*p+1], w[2*p]};
      for (int c = 0; c < (1 << dec); c++) exp_q.push_back({pr, 1'b1, 1'b0});
      last_ch = pr;
    end
  endtask

  task automatic exp_underrun();
    exp_q.push_back({exp_idle(last_ch), 1'b0, 1'b1});
  endtask

  task automatic push_word(input logic [7:0] w);
    int n;
    smpl     = w;
    smpl_vld = 1'b1;
    n = 0;
    while (!smpl_rdy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!smpl_rdy) begin
      checks++;
      failures++;
      $display("FAIL push_timeout got=rdy0 exp=rdy1");
    end
    @(posedge clk);
    #1;
    smpl_vld = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_drain got=%0d_left exp=0_left", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    check({name, "_idle_ch"}, 32'({CH_H, CH_L}), 32'(exp_idle(last_ch)));
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  // Monitor: every busy or underrun cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      got = {CH_H, CH_L, busy, underrun};
      if (busy || underrun) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output got=%b exp=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL trace got=%b exp=%b", got, e);
          end
          in_word = !e.und;
        end
      end else if (in_word) begin
        checks++;
        failures++;
        $display("FAIL gap got=%b exp=busy_or_underrun", got);
        in_word = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; decimator = 4'd0; smpl = 8'h00; smpl_vld = 1'b0;
    #3;
    check("rst_ch", 32'({CH_H, CH_L}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_rdy", 32'(smpl_rdy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Pairs of 10_01_11_00 oldest first: 00, 11, 01, 10.
    en = 1'b1; decimator = 4'd0;
    exp_q.push_back({2'b00, 1'b1, 1'b0});
    exp_q.push_back({2'b11, 1'b1, 1'b0});
    exp_q.push_back({2'b01, 1'b1, 1'b0});
    exp_q.push_back({2'b10, 1'b1, 1'b0});
    last_ch = 2'b10;
    exp_underrun();
    @(negedge clk);
    push_word(8'b10_01_11_00);
    @(negedge clk);
    check("lat_not_yet", 32'(busy), 32'd0);
    @(negedge clk);
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_pair0", 32'({CH_H, CH_L}), 32'd0);
    wait_drain("t1");

    // A5 -> 01,01,10,10 ; 3C -> 00,11,11,00 ; 4 cycles each, no gap.
    decimator = 4'd2;
    exp_word(8'hA5, 2);
    exp_word(8'h3C, 2);
    exp_underrun();
    @(negedge clk);
    push_word(8'hA5);
    push_word(8'h3C);
    wait_drain("t2");

    // Fill with replay disabled; fifth word stalls until the first pop.
    en = 1'b0; decimator = 4'd0;
    exp_word(8'h1B, 0);
    exp_word(8'hE4, 0);
    exp_word(8'h55, 0);
    exp_word(8'hAA, 0);
    exp_word(8'h0F, 0);
    exp_underrun();
    @(negedge clk);
    push_word(8'h1B);
    check("rdy_after1", 32'(smpl_rdy), 32'd1);
    push_word(8'hE4);
    push_word(8'h55);
    push_word(8'hAA);
    check("rdy_full", 32'(smpl_rdy), 32'd0);
    smpl = 8'h0F; smpl_vld = 1'b1;
    repeat (3) @(negedge clk);
    check("rdy_stall", 32'(smpl_rdy), 32'd0);
    check("busy_stall", 32'(busy), 32'd0);
    en = 1'b1;
    push_word(8'h0F);
    wait_drain("t3");

    // decimator 15 saturates to 9: 93 -> 11,00,01,10 held 512 cycles each.
    decimator = 4'd15;
    exp_word(8'h93, 9);
    exp_underrun();
    @(negedge clk);
    push_word(8'h93);
    wait_drain("t4");

    // Asynchronous reset mid-pair discards the word in flight and the buffered one.
    mon_en = 1'b0;
    en = 1'b0; decimator = 4'd2;
    @(negedge clk);
    push_word(8'hFF);
    push_word(8'h77);
    @(negedge clk);
    en = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ch", 32'({CH_H, CH_L}), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_rdy", 32'(smpl_rdy), 32'd1);
    check("arst_underrun", 32'(underrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("post_rst_empty", 32'(busy), 32'd0);
    end
    in_word = 1'b0;
    mon_en = 1'b1;

    // C0 -> 00,00,00,11; after underrun outputs go idle (or hold 11).
    decimator = 4'd0;
    exp_word(8'hC0, 0);
    exp_underrun();
    @(negedge clk);
    push_word(8'hC0);
    wait_drain("t6");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t6_hold", 32'({CH_H, CH_L, busy, underrun}), 32'({exp_idle(2'b11), 2'b00}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
